// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response bundle for the multi-cycle EX-stage ALU.
//   Request  : in_valid/in_ready handshake, alusrc, din1, dreg, dext, aluctrl.
//   Response : out_valid/out_ready handshake, aluresult, aluzero, aluovf, illegal.
//   master = producer of operations (pipeline side), slave = the ALU.
interface alu_mc_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic             alusrc;
   logic [WIDTH-1:0] din1;
   logic [WIDTH-1:0] dreg;
   logic [WIDTH-1:0] dext;
   logic [3:0]       aluctrl;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] aluresult;
   logic             aluzero;
   logic             aluovf;
   logic             illegal;

   modport master (
      output in_valid, alusrc, din1, dreg, dext, aluctrl, out_ready,
      input  in_ready, out_valid, aluresult, aluzero, aluovf, illegal
   );

   modport slave (
      input  in_valid, alusrc, din1, dreg, dext, aluctrl, out_ready,
      output in_ready, out_valid, aluresult, aluzero, aluovf, illegal
   );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the EX stage.
//   clk, rst : rising-edge clock, asynchronous active-high reset.
//   bus      : alu_mc_if.slave -- operation request (in_valid/in_ready,
//              alusrc, din1, dreg, dext, aluctrl) and registered response
//              (out_valid/out_ready, aluresult, aluzero, aluovf, illegal).
// Single-cycle ops register their result on the accept edge. MULU runs a
// shift-add loop and DIVU/REMU a restoring-division loop, one step per cycle
// for WIDTH cycles. Division by zero bypasses the loop.
module alu_mc #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic    clk,
   input logic    rst,
   alu_mc_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t state, state_nxt;

   logic [SHW-1:0]   cnt;
   logic [3:0]       op_p0;
   logic [WIDTH-1:0] a_p0, b_p0, acc_p0, quo_p0;

   logic                    accept, multi, last;
   logic [WIDTH-1:0]        bsel;
   logic [SHW-1:0]          sh;
   logic signed [WIDTH-1:0] a_s, b_s;
   logic [WIDTH-1:0]        sum, dif, sc_res;
   logic                    sc_ovf, sc_ill;
   logic [WIDTH-1:0]        mul_acc, div_quo, div_rem, step_res;
   logic [WIDTH:0]          div_t, div_d;
   logic                    div_ge;

   function automatic logic add_ovf(input logic [WIDTH-1:0] a, b, r);
      return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
   endfunction

   function automatic logic sub_ovf(input logic [WIDTH-1:0] a, b, r);
      return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
   endfunction

   assign bsel   = bus.alusrc ? bus.dext : bus.dreg;
   assign accept = (state == IDLE) && bus.in_valid;
   // Zero divisor skips the iterative loop and is answered immediately.
   assign multi  = (bus.aluctrl == 4'd11) ||
                   (((bus.aluctrl == 4'd12) || (bus.aluctrl == 4'd13)) && (bsel != '0));
   assign last   = (state == BUSY) && (cnt == SHW'(WIDTH - 1));

   // Single-cycle result path
   always_comb begin
      a_s    = signed'(bus.din1);
      b_s    = signed'(bsel);
      sh     = bsel[SHW-1:0];
      sum    = bus.din1 + bsel;
      dif    = bus.din1 - bsel;
      sc_res = '0;
      sc_ovf = 1'b0;
      sc_ill = 1'b0;
      case (bus.aluctrl)
         4'd0:  begin sc_res = sum; sc_ovf = add_ovf(bus.din1, bsel, sum); end
         4'd1:  begin sc_res = dif; sc_ovf = sub_ovf(bus.din1, bsel, dif); end
         4'd2:  sc_res = bus.din1 & bsel;
         4'd3:  sc_res = bus.din1 | bsel;
         4'd4:  sc_res = bus.din1 ^ bsel;
         4'd5:  sc_res = ~(bus.din1 | bsel);
         4'd6:  sc_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
         4'd7:  sc_res = {{(WIDTH-1){1'b0}}, (bus.din1 < bsel)};
         4'd8:  sc_res = bus.din1 << sh;
         4'd9:  sc_res = bus.din1 >> sh;
         4'd10: sc_res = $unsigned(a_s >>> sh);
         4'd12: sc_res = '1;        // divide by zero only
         4'd13: sc_res = bus.din1;  // divide by zero only
         4'd11: sc_res = '0;
         default: sc_ill = 1'b1;
      endcase
   end

   // Iteration step: multiplier bits are consumed LSB first from quo_p0 while
   // the multiplicand shifts left; division shifts dividend bits MSB first
   // into the partial remainder held in acc_p0.
   always_comb begin
      mul_acc  = acc_p0 + (quo_p0[0] ? a_p0 : '0);
      div_t    = {acc_p0, quo_p0[WIDTH-1]};
      div_d    = div_t - {1'b0, b_p0};
      div_ge   = (div_t >= {1'b0, b_p0});
      div_rem  = div_ge ? div_d[WIDTH-1:0] : div_t[WIDTH-1:0];
      div_quo  = {quo_p0[WIDTH-2:0], div_ge};
      step_res = (op_p0 == 4'd11) ? mul_acc : ((op_p0 == 4'd12) ? div_quo : div_rem);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nxt = multi ? BUSY : DONE;
         end
         BUSY: if (last) state_nxt = DONE;
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture (p0) and iteration datapath
   always_ff @(posedge clk) begin
      if (accept) begin
         op_p0  <= bus.aluctrl;
         a_p0   <= bus.din1;
         b_p0   <= bsel;
         quo_p0 <= (bus.aluctrl == 4'd11) ? bsel : bus.din1;
         acc_p0 <= '0;
      end else if (state == BUSY) begin
         if (op_p0 == 4'd11) begin
            acc_p0 <= mul_acc;
            a_p0   <= a_p0 << 1;
            quo_p0 <= quo_p0 >> 1;
         end else begin
            acc_p0 <= div_rem;
            quo_p0 <= div_quo;
         end
      end
   end

   // Iteration counter and registered result/flags (p1)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt           <= '0;
         bus.aluresult <= '0;
         bus.aluzero   <= 1'b0;
         bus.aluovf    <= 1'b0;
         bus.illegal   <= 1'b0;
      end else if (accept) begin
         cnt <= '0;
         if (!multi) begin
            bus.aluresult <= sc_res;
            bus.aluzero   <= (sc_res == '0);
            bus.aluovf    <= sc_ovf;
            bus.illegal   <= sc_ill;
         end
      end else if (state == BUSY) begin
         cnt <= cnt + SHW'(1);
         if (last) begin
            bus.aluresult <= step_res;
            bus.aluzero   <= (step_res == '0);
            bus.aluovf    <= 1'b0;
            bus.illegal   <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and randomized checks of alu_mc against a plain
// arithmetic reference model (WIDTH=32).
module tb_alu_mc;
   localparam int W = 32;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   alu_mc_if #(.WIDTH(W)) bus();
   alu_mc #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: result, overflow, illegal and latency from the opcode rules.
   function automatic void model(input logic [3:0] op, input logic [W-1:0] a, b,
                                 output logic [W-1:0] res, output logic ovf,
                                 output logic ill, output int lat);
      longint          sa, sb, s, lim;
      longint unsigned p;
      int              sh;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      lim = longint'(1) <<< (W - 1);
      sh  = int'(b % W);
      res = '0; ovf = 1'b0; ill = 1'b0; lat = 1;
      case (op)
         4'd0:  begin s = sa + sb; res = a + b; ovf = (s >= lim) || (s < -lim); end
         4'd1:  begin s = sa - sb; res = a - b; ovf = (s >= lim) || (s < -lim); end
         4'd2:  res = a & b;
         4'd3:  res = a | b;
         4'd4:  res = a ^ b;
         4'd5:  res = ~(a | b);
         4'd6:  res = (sa < sb) ? 1 : 0;
         4'd7:  res = (a < b) ? 1 : 0;
         4'd8:  res = a << sh;
         4'd9:  res = a >> sh;
         4'd10: res = $signed(a) >>> sh;
         4'd11: begin p = 64'(a) * 64'(b); res = p[W-1:0]; lat = W + 1; end
         4'd12: if (b == 0) res = '1; else begin res = a / b; lat = W + 1; end
         4'd13: if (b == 0) res = a;  else begin res = a % b; lat = W + 1; end
         default: ill = 1'b1;
      endcase
   endfunction

   // Issue one op from IDLE (#1 after a rising edge), wait for the result,
   // compare everything, then consume it.
   task automatic run_op(input string tag, input logic [3:0] op, input logic src,
                         input logic [W-1:0] a, r, e);
      logic [W-1:0] b, er;
      logic         eo, ei;
      int           el, lat;
      logic         busy_ok;
      b = src ? e : r;
      model(op, a, b, er, eo, ei, el);
      bus.aluctrl = op; bus.alusrc = src; bus.din1 = a; bus.dreg = r; bus.dext = e;
      bus.in_valid = 1'b1;
      check({tag, ".in_ready"}, W'(bus.in_ready), W'(1));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.din1 = $urandom; bus.dreg = $urandom; bus.dext = $urandom;
      lat = 1; busy_ok = 1'b1;
      while (bus.out_valid !== 1'b1 && lat < 3 * W) begin
         if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      check({tag, ".latency"}, W'(lat), W'(el));
      check({tag, ".busy"}, W'(busy_ok), W'(1));
      check({tag, ".result"}, bus.aluresult, er);
      check({tag, ".zero"}, W'(bus.aluzero), W'(er == 0));
      check({tag, ".ovf"}, W'(bus.aluovf), W'(eo));
      check({tag, ".illegal"}, W'(bus.illegal), W'(ei));
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check({tag, ".drained"}, W'(bus.out_valid), W'(0));
   endtask

   initial begin
      logic [3:0]   op;
      logic [W-1:0] a, bv, other;
      logic         src, stale;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.alusrc = 1'b0;
      bus.din1 = '0; bus.dreg = '0; bus.dext = '0; bus.aluctrl = '0;
      #1;
      check("rst.out_valid", W'(bus.out_valid), W'(0));
      check("rst.result", bus.aluresult, W'(0));
      check("rst.zero", W'(bus.aluzero), W'(0));
      check("rst.ovf", W'(bus.aluovf), W'(0));
      check("rst.illegal", W'(bus.illegal), W'(0));
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      check("rst.in_ready", W'(bus.in_ready), W'(1));

      run_op("add",   4'd0,  1'b0, 32'd5, 32'd3, 32'd0);
      run_op("subi",  4'd1,  1'b1, 32'd5, 32'd99, 32'd2);
      run_op("subz",  4'd1,  1'b0, 32'd5, 32'd5, 32'd0);
      run_op("addov", 4'd0,  1'b0, 32'h7FFFFFFF, 32'd1, 32'd0);
      run_op("sra",   4'd10, 1'b0, 32'h80000000, 32'h24, 32'd0);
      run_op("slt",   4'd6,  1'b0, 32'hFFFFFFFF, 32'd1, 32'd0);
      run_op("sltu",  4'd7,  1'b0, 32'hFFFFFFFF, 32'd1, 32'd0);
      run_op("mulu",  4'd11, 1'b0, 32'h00010000, 32'h00010001, 32'd0);
      run_op("divu",  4'd12, 1'b0, 32'd100, 32'd7, 32'd0);
      run_op("remu",  4'd13, 1'b0, 32'd100, 32'd7, 32'd0);
      run_op("div0",  4'd12, 1'b0, 32'd100, 32'd0, 32'd0);
      run_op("rem0",  4'd13, 1'b0, 32'd100, 32'd0, 32'd0);
      run_op("ill15", 4'd15, 1'b0, 32'd7, 32'd9, 32'd0);

      // Back-pressure: result held while a second op waits at the input.
      bus.aluctrl = 4'd0; bus.alusrc = 1'b0; bus.din1 = 32'd5; bus.dreg = 32'd3;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.aluctrl = 4'd1; bus.din1 = 32'd9; bus.dreg = 32'd4;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("hold.valid", W'(bus.out_valid), W'(1));
         check("hold.result", bus.aluresult, W'(8));
         check("hold.flags", W'({bus.aluzero, bus.aluovf, bus.illegal}), W'(0));
         check("hold.in_ready", W'(bus.in_ready), W'(0));
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      check("hold.release", W'(bus.out_valid), W'(0));
      check("hold.idle", W'(bus.in_ready), W'(1));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("pend.valid", W'(bus.out_valid), W'(1));
      check("pend.result", bus.aluresult, W'(5));
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;

      // Reset in the middle of a multiply.
      bus.aluctrl = 4'd11; bus.alusrc = 1'b0; bus.din1 = 32'h12345; bus.dreg = 32'h777;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort.out_valid", W'(bus.out_valid), W'(0));
      check("abort.result", bus.aluresult, W'(0));
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      check("abort.in_ready", W'(bus.in_ready), W'(1));
      stale = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (bus.out_valid !== 1'b0) stale = 1'b1;
         @(posedge clk); #1;
      end
      check("abort.stale", W'(stale), W'(0));
      run_op("post", 4'd0, 1'b0, 32'd20, 32'd22, 32'd0);

      // Randomized operations.
      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         case ($urandom_range(0, 3))
            0:       bv = '0;
            1:       bv = 32'($urandom_range(1, 20));
            default: bv = $urandom;
         endcase
         src   = 1'($urandom_range(0, 1));
         other = $urandom;
         if (src) run_op($sformatf("rnd%0d", i), op, src, a, other, bv);
         else     run_op($sformatf("rnd%0d", i), op, src, a, bv, other);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
